// File: rtl/subtrator_serial_pkg.sv
// subtrator_serial_pkg: shared state encoding and default width for the serial subtractor
package subtrator_serial_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/subtrator_serial_completo.sv
// subtratorCompleto: one-bit full subtractor, x - y - bin
module subtratorCompleto (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/subtrator_serial.sv
// subtrator_serial: bit-serial A - B - Bin, LSB first, started by an active-low button
module subtrator_serial
  import subtrator_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_n,
  input  logic [WIDTH-1:0] a_n,
  input  logic [WIDTH-1:0] b_n,
  input  logic             bin_n,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2:0]       sync_q;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d, res_q, res_d;
  logic             borrow_q, borrow_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             strobe, dbit, bo;
  // sync_q[2] is the edge-history flop; a press is a 1->0 transition of the synced level
  assign strobe = sync_q[2] & ~sync_q[1];
  subtratorCompleto u_cell (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (borrow_q),
    .d   (dbit),
    .bout(bo)
  );
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    bout_d   = bout_q;
    case (state_q)
      S_IDLE: if (strobe) begin
        a_d      = ~a_n;
        b_d      = ~b_n;
        borrow_d = ~bin_n;
        diff_d   = '0;
        cnt_d    = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        diff_d   = {dbit, diff_q[WIDTH-1:1]};
        borrow_d = bo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d   = {dbit, diff_q[WIDTH-1:1]};
          bout_d  = bo;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '1;
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      bout_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], start_n};
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      bout_q   <= bout_d;
    end
  end
  assign d    = res_q;
  assign bout = bout_q;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
endmodule

// File: tb/tb_subtrator_serial.sv
// tb_subtrator_serial: scoreboard bench for the bit-serial subtractor
module tb_subtrator_serial;
  typedef struct packed {
    logic [3:0] d;
    logic       bo;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_n = 1'b1;
  logic [3:0] a_n = '1, b_n = '1;
  logic       bin_n = 1'b1;
  logic [3:0] d;
  logic       bout, busy, done;
  exp_t       sb[$];
  int         n_checks = 0, n_fail = 0, done_cnt = 0;
  subtrator_serial #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_n(start_n), .a_n(a_n), .b_n(b_n),
    .bin_n(bin_n), .d(d), .bout(bout), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic bi);
    logic [4:0] t;
    t = {1'b0, a} - {1'b0, b} - {4'b0, bi};
    return '{d: t[3:0], bo: t[4]};
  endfunction
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: d=%0d bout=%0b with empty scoreboard", d, bout);
      end else begin
        e = sb.pop_front();
        if (d !== e.d || bout !== e.bo) begin
          n_fail++;
          $display("FAIL result: got d=%0d bout=%0b, expected d=%0d bout=%0b", d, bout, e.d, e.bo);
        end
      end
    end
  end
  task automatic set_ops(input logic [3:0] a, input logic [3:0] b, input logic bi);
    a_n = ~a; b_n = ~b; bin_n = ~bi;
  endtask
  task automatic test_reset;
    #2;
    n_checks++;
    if ({d, bout, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state: got d=%0d bout=%0b busy=%0b done=%0b, expected all 0", d, bout, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bi);
    int lat = -1;
    sb.push_back(model(a, b, bi));
    set_ops(a, b, bi);
    start_n = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_before_capture: got %0b, expected 0", busy); end
      end
      if (k == 2) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_capture: got %0b, expected 1", busy); end
      end
      if (done) lat = k;
    end
    n_checks++;
    if (lat != 6) begin n_fail++; $display("FAIL latency: got %0d edges, expected 6", lat); end
    start_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: got done=%0b busy=%0b, expected 0 0", done, busy);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_arith;
    run_op(4'd5, 4'd3, 1'b0);
    run_op(4'd3, 4'd5, 1'b0);
    run_op(4'd0, 4'd0, 1'b1);
    run_op(4'd15, 4'd15, 1'b0);
    run_op(4'd8, 4'd7, 1'b1);
    run_op(4'd10, 4'd6, 1'b1);
  endtask
  task automatic test_hold;
    int c0 = done_cnt;
    sb.push_back(model(4'd12, 4'd5, 1'b0));
    set_ops(4'd12, 4'd5, 1'b0);
    start_n = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt - c0 != 1) begin n_fail++; $display("FAIL hold_one_op: got %0d done pulses, expected 1", done_cnt - c0); end
    start_n = 1'b1;
    repeat (4) @(negedge clk);
    sb.push_back(model(4'd12, 4'd5, 1'b0));
    start_n = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (done_cnt - c0 != 2) begin n_fail++; $display("FAIL hold_repress: got %0d done pulses, expected 2", done_cnt - c0); end
    start_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_ignore_press;
    int c0 = done_cnt;
    sb.push_back(model(4'd9, 4'd4, 1'b0));
    set_ops(4'd9, 4'd4, 1'b0);
    start_n = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k == 1) start_n = 1'b1;
      if (k == 3) begin start_n = 1'b0; a_n = ~4'd15; end
    end
    n_checks++;
    if (done_cnt - c0 != 1) begin n_fail++; $display("FAIL press_in_shift: got %0d done pulses, expected 1", done_cnt - c0); end
    start_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int first = -1, second = -1;
    sb.push_back(model(4'd6, 4'd2, 1'b1));
    sb.push_back(model(4'd2, 4'd6, 1'b0));
    set_ops(4'd6, 4'd2, 1'b1);
    start_n = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 1) start_n = 1'b1;
      if (k == 5) start_n = 1'b0;
      if (k == 6) set_ops(4'd2, 4'd6, 1'b0);
      if (done && first < 0) first = k;
      else if (done && second < 0) second = k;
    end
    n_checks++;
    if (first != 6 || second != 12) begin
      n_fail++;
      $display("FAIL back_to_back: got done at %0d,%0d, expected 6,12", first, second);
    end
    start_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset_abort;
    int c0 = done_cnt;
    set_ops(4'd7, 4'd1, 1'b0);
    start_n = 1'b0;
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({d, bout, busy, done} !== 7'b0) begin
      n_fail++;
      $display("FAIL abort_state: got d=%0d bout=%0b busy=%0b done=%0b, expected all 0", d, bout, busy, done);
    end
    @(negedge clk);
    start_n = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_cnt != c0 || d !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got pulses=%0d d=%0d busy=%0b, expected 0 0 0", done_cnt - c0, d, busy);
    end
    run_op(4'd11, 4'd2, 1'b1);
  endtask
  initial begin
    test_reset;
    test_arith;
    test_hold;
    test_ignore_press;
    test_back_to_back;
    test_reset_abort;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
